sd_cmd_responder: RTL and testbench

SD_CMD_RESPONDER -- requirements
Module: sd_cmd_responder

---
 rtl/sd_cmd_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_sd_cmd_responder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_responder.sv
// SD card CMD-line responder: receives 48-bit host commands, checks framing
// (and optionally CRC7), reports the command, then optionally drives a short
// (48-bit) or long (136-bit) response back on the shared CMD line.
// Build option: define SD_CMD_CRC_CHECK_EN to reject commands whose CRC7 is
// wrong; when undefined the received CRC is ignored and CRC_ERR stays 0.
module sd_cmd_responder #(
    parameter int NCR       = 2,
    parameter int RESP_WAIT = 64
) (
    input  logic         CLK_PAD_IO,
    input  logic         RST_PAD_I,
    input  logic         BIT_EN,
    input  logic         cmd_dat_i,
    output logic         cmd_out_o,
    output logic         cmd_oe_o,
    output logic         CMD_VALID,
    output logic [5:0]   CMD_INDEX,
    output logic [31:0]  ARG,
    output logic         CRC_ERR,
    output logic         FRAME_ERR,
    input  logic         RESP_REQ,
    input  logic [1:0]   RESP_TYPE,
    input  logic [127:0] RESP_DATA,
    output logic         RESP_TO,
    output logic         BUSY
);

    typedef enum logic [2:0] {IDLE, RECV, CHECK, WAIT_RESP, SEND} state_t;

    localparam logic [8:0] LP_NCR       = 9'(NCR);
    localparam logic [8:0] LP_RESP_WAIT = 9'(RESP_WAIT);

    state_t         r_state;
    state_t         w_nextState;
    logic [46:0]    r_rxShift;
    logic [5:0]     r_rxCnt;
`ifdef SD_CMD_CRC_CHECK_EN
    logic [6:0]     r_rxCrc;
`endif
    logic [7:0]     r_waitCnt;
    logic [8:0]     w_elapsed;
    logic [135:0]   r_txShift;
    logic [7:0]     r_txPos;
    logic [6:0]     r_txCrc;
    logic           r_txLong;
    logic           r_cmdValid;
    logic           r_crcErr;
    logic           r_frameErr;
    logic           r_respTo;
    logic [5:0]     r_cmdIndex;
    logic [31:0]    r_arg;
    logic           w_frameBad;
    logic           w_crcBad;
    logic           w_cmdValidNext;
    logic           w_crcErrNext;
    logic           w_frameErrNext;
    logic           w_respToNext;
    logic           w_startSend;
    logic           w_txBit;

    // One serial step of CRC7 (x^7 + x^3 + 1), MSB of the message first.
    function automatic logic [6:0] crc7Step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

    // Bit-times seen in WAIT_RESP including the current BIT_EN cycle.
    assign w_elapsed  = {1'b0, r_waitCnt} + 9'd1;
    // After the end bit, r_rxShift[46] is the transmission bit and [0] the end bit.
    assign w_frameBad = ~r_rxShift[46] | ~r_rxShift[0];
`ifdef SD_CMD_CRC_CHECK_EN
    assign w_crcBad   = (r_rxCrc != r_rxShift[7:1]);
`else
    assign w_crcBad   = 1'b0;
`endif
    assign w_startSend = (r_state == WAIT_RESP) && (w_nextState == SEND);

    // Response line value: payload bits first, then the CRC7, then the end bit.
    assign w_txBit   = (r_txPos >= 8'd8) ? r_txShift[135] :
                       ((r_txPos != 8'd0) ? r_txCrc[6] : 1'b1);
    assign cmd_oe_o  = (r_state == SEND);
    assign cmd_out_o = cmd_oe_o ? w_txBit : 1'b1;
    assign BUSY      = (r_state != IDLE);
    assign CMD_VALID = r_cmdValid;
    assign CRC_ERR   = r_crcErr;
    assign FRAME_ERR = r_frameErr;
    assign RESP_TO   = r_respTo;
    assign CMD_INDEX = r_cmdIndex;
    assign ARG       = r_arg;

    // State register; reset drops straight to IDLE, which also releases the line.
    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) r_state <= IDLE;
        else           r_state <= w_nextState;
    end

    // Next-state decode and the one-cycle status pulses that leave each state.
    always_comb begin
        w_nextState    = r_state;
        w_cmdValidNext = 1'b0;
        w_crcErrNext   = 1'b0;
        w_frameErrNext = 1'b0;
        w_respToNext   = 1'b0;
        case (r_state)
            IDLE: begin
                if (BIT_EN && !cmd_dat_i) w_nextState = RECV;
            end
            RECV: begin
                if (BIT_EN && (r_rxCnt == 6'd0)) w_nextState = CHECK;
            end
            CHECK: begin
                if (w_frameBad) begin
                    w_frameErrNext = 1'b1;
                    w_nextState    = IDLE;
                end else if (w_crcBad) begin
                    w_crcErrNext = 1'b1;
                    w_nextState  = IDLE;
                end else begin
                    w_cmdValidNext = 1'b1;
                    w_nextState    = (RESP_TYPE == 2'b00) ? IDLE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (BIT_EN) begin
                    if (RESP_REQ && (w_elapsed >= LP_NCR)) begin
                        w_nextState = SEND;
                    end else if (w_elapsed >= LP_RESP_WAIT) begin
                        w_respToNext = 1'b1;
                        w_nextState  = IDLE;
                    end
                end
            end
            SEND: begin
                if (BIT_EN && (r_txPos == 8'd0)) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Registered status pulses plus the command index/argument captured on success.
    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            r_cmdValid <= 1'b0;
            r_crcErr   <= 1'b0;
            r_frameErr <= 1'b0;
            r_respTo   <= 1'b0;
            r_cmdIndex <= '0;
            r_arg      <= '0;
        end else begin
            r_cmdValid <= w_cmdValidNext;
            r_crcErr   <= w_crcErrNext;
            r_frameErr <= w_frameErrNext;
            r_respTo   <= w_respToNext;
            if (w_cmdValidNext) begin
                r_cmdIndex <= r_rxShift[45:40];
                r_arg      <= r_rxShift[39:8];
            end
        end
    end

    // Receive shifter: counter starts at 46 on the start bit and counts down to the end bit.
    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            r_rxShift <= '0;
            r_rxCnt   <= '0;
        end else if (BIT_EN) begin
            if ((r_state == IDLE) && !cmd_dat_i) begin
                r_rxShift <= '0;
                r_rxCnt   <= 6'd46;
            end else if (r_state == RECV) begin
                r_rxShift <= {r_rxShift[45:0], cmd_dat_i};
                if (r_rxCnt != 6'd0) r_rxCnt <= r_rxCnt - 6'd1;
            end
        end
    end

`ifdef SD_CMD_CRC_CHECK_EN
    // Running CRC7 over frame bits 46..8; the start bit is 0 so it leaves the zero seed unchanged.
    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            r_rxCrc <= '0;
        end else if (BIT_EN) begin
            if ((r_state == IDLE) && !cmd_dat_i) r_rxCrc <= '0;
            else if ((r_state == RECV) && (r_rxCnt >= 6'd8)) r_rxCrc <= crc7Step(r_rxCrc, cmd_dat_i);
        end
    end
`endif

    // Bit-time counter for the response window, cleared while the command is judged.
    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I)                              r_waitCnt <= '0;
        else if (r_state == CHECK)                  r_waitCnt <= '0;
        else if ((r_state == WAIT_RESP) && BIT_EN)  r_waitCnt <= w_elapsed[7:0];
    end

    // Transmit shifter: r_txPos is the frame position currently on the line; the CRC is built as bits leave.
    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            r_txShift <= '0;
            r_txPos   <= '0;
            r_txCrc   <= '0;
            r_txLong  <= 1'b0;
        end else if (w_startSend) begin
            r_txCrc  <= '0;
            r_txLong <= (RESP_TYPE == 2'b01);
            if (RESP_TYPE == 2'b01) begin
                r_txShift <= {2'b00, 6'h3F, RESP_DATA[127:8], 8'h00};
                r_txPos   <= 8'd135;
            end else begin
                r_txShift <= {2'b00, r_cmdIndex, RESP_DATA[31:0], 96'h0};
                r_txPos   <= 8'd47;
            end
        end else if ((r_state == SEND) && BIT_EN && (r_txPos != 8'd0)) begin
            if (r_txPos >= 8'd8) begin
                if (!r_txLong || (r_txPos <= 8'd127)) r_txCrc <= crc7Step(r_txCrc, r_txShift[135]);
                r_txShift <= {r_txShift[134:0], 1'b0};
            end else begin
                r_txCrc <= {r_txCrc[5:0], 1'b0};
            end
            r_txPos <= r_txPos - 8'd1;
        end
    end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Scoreboard bench for sd_cmd_responder: stimulus pushes expected events and
// response frames into a queue, an independent monitor pops and compares them.
module tb_sd_cmd_responder;

    localparam int K_VALID = 0;
    localparam int K_CRC   = 1;
    localparam int K_FRAME = 2;
    localparam int K_TO    = 3;
    localparam int K_RESP  = 4;

    typedef struct {
        int           kind;
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [135:0] frame;
        int           len;
        int           gap;
    } exp_t;

    logic         CLK_PAD_IO;
    logic         RST_PAD_I;
    logic         BIT_EN;
    logic         cmd_dat_i;
    logic         cmd_out_o;
    logic         cmd_oe_o;
    logic         CMD_VALID;
    logic [5:0]   CMD_INDEX;
    logic [31:0]  ARG;
    logic         CRC_ERR;
    logic         FRAME_ERR;
    logic         RESP_REQ;
    logic [1:0]   RESP_TYPE;
    logic [127:0] RESP_DATA;
    logic         RESP_TO;
    logic         BUSY;

    exp_t         expQ[$];
    int           checks = 0;
    int           errors = 0;
    logic [135:0] capFrame;
    int           capCnt;
    int           gapCnt;
    int           gapAtStart;

    sd_cmd_responder #(.NCR(2), .RESP_WAIT(64)) dut (
        .CLK_PAD_IO (CLK_PAD_IO),
        .RST_PAD_I  (RST_PAD_I),
        .BIT_EN     (BIT_EN),
        .cmd_dat_i  (cmd_dat_i),
        .cmd_out_o  (cmd_out_o),
        .cmd_oe_o   (cmd_oe_o),
        .CMD_VALID  (CMD_VALID),
        .CMD_INDEX  (CMD_INDEX),
        .ARG        (ARG),
        .CRC_ERR    (CRC_ERR),
        .FRAME_ERR  (FRAME_ERR),
        .RESP_REQ   (RESP_REQ),
        .RESP_TYPE  (RESP_TYPE),
        .RESP_DATA  (RESP_DATA),
        .RESP_TO    (RESP_TO),
        .BUSY       (BUSY)
    );

    // Free-running clock.
    initial begin
        CLK_PAD_IO = 1'b0;
        forever #5 CLK_PAD_IO = ~CLK_PAD_IO;
    end

    // One BIT_EN strobe every fourth clock, changed just after the rising edge.
    initial begin
        int divCnt;
        divCnt = 0;
        BIT_EN = 1'b0;
        forever begin
            @(posedge CLK_PAD_IO);
            #1;
            divCnt = divCnt + 1;
            BIT_EN = ((divCnt % 4) == 0);
        end
    end

    // Hard stop in case something wedges the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [135:0] actual, input logic [135:0] required);
        checks = checks + 1;
        if (actual !== required) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    task automatic pushExp(input int kind, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [135:0] frame, input int len, input int gap);
        exp_t e;
        e.kind = kind; e.idx = idx; e.arg = arg; e.frame = frame; e.len = len; e.gap = gap;
        expQ.push_back(e);
    endtask

    task automatic handleEvent(input int kind);
        exp_t e;
        if (expQ.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL unexpected event: got kind %0d, expected nothing", kind);
        end else begin
            e = expQ.pop_front();
            checkOutput("event kind", 136'(kind), 136'(e.kind));
            if (kind == K_VALID && e.kind == K_VALID) begin
                checkOutput("CMD_INDEX", 136'(CMD_INDEX), 136'(e.idx));
                checkOutput("ARG", 136'(ARG), 136'(e.arg));
            end
            if (kind == K_TO && e.kind == K_TO)
                checkOutput("timeout bit-times", 136'(gapCnt), 136'(e.gap));
        end
    endtask

    task automatic finishResp();
        exp_t e;
        if (expQ.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL unexpected response: got %0d bits %0h, expected nothing", capCnt, capFrame);
        end else begin
            e = expQ.pop_front();
            checkOutput("response kind", 136'(K_RESP), 136'(e.kind));
            checkOutput("response length", 136'(capCnt), 136'(e.len));
            checkOutput("response frame", capFrame, e.frame);
            checkOutput("response NCR gap", 136'(gapAtStart), 136'(e.gap));
        end
    endtask

    // Monitor: samples on the falling edge, matches pulses and driven frames against the queue.
    initial begin
        capFrame = '0;
        capCnt = 0;
        gapCnt = -1;
        gapAtStart = 0;
        forever begin
            @(negedge CLK_PAD_IO);
            if (RST_PAD_I) begin
                capFrame = '0;
                capCnt = 0;
                gapCnt = -1;
            end else begin
                if (CMD_VALID) begin handleEvent(K_VALID); gapCnt = 0; end
                if (CRC_ERR)   handleEvent(K_CRC);
                if (FRAME_ERR) handleEvent(K_FRAME);
                if (RESP_TO)   begin handleEvent(K_TO); gapCnt = -1; end
                if (BIT_EN) begin
                    if (cmd_oe_o) begin
                        if (capCnt == 0) gapAtStart = gapCnt;
                        capFrame = {capFrame[134:0], cmd_out_o};
                        capCnt = capCnt + 1;
                    end else if (capCnt > 0) begin
                        finishResp();
                        capFrame = '0;
                        capCnt = 0;
                        gapCnt = -1;
                    end else if (gapCnt >= 0) begin
                        gapCnt = gapCnt + 1;
                    end
                end
            end
        end
    end

    task automatic sendBit(input logic b);
        cmd_dat_i = b;
        do @(posedge CLK_PAD_IO); while (!BIT_EN);
        #1;
    endtask

    task automatic applyStimulus(input logic [47:0] frame);
        for (int i = 47; i >= 0; i--) sendBit(frame[i]);
        cmd_dat_i = 1'b1;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 4000) begin
            @(posedge CLK_PAD_IO);
            n = n + 1;
        end
        if (expQ.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL drain timeout: got %0d pending, expected 0", expQ.size());
            expQ.delete();
        end
        repeat (16) @(posedge CLK_PAD_IO);
        #1;
        checkOutput("BUSY when idle", 136'(BUSY), 136'(0));
    endtask

    // Directed sequence of commands and responses.
    initial begin
        int sent;
        int n;
        RST_PAD_I = 1'b1;
        cmd_dat_i = 1'b1;
        RESP_REQ  = 1'b0;
        RESP_TYPE = 2'b00;
        RESP_DATA = '0;
        repeat (3) @(posedge CLK_PAD_IO);
        #1;
        checkOutput("reset cmd_oe_o", 136'(cmd_oe_o), 136'(0));
        checkOutput("reset cmd_out_o", 136'(cmd_out_o), 136'(1));
        checkOutput("reset BUSY", 136'(BUSY), 136'(0));
        checkOutput("reset pulses", 136'({CMD_VALID, CRC_ERR, FRAME_ERR, RESP_TO}), 136'(0));
        checkOutput("reset CMD_INDEX", 136'(CMD_INDEX), 136'(0));
        checkOutput("reset ARG", 136'(ARG), 136'(0));
        RST_PAD_I = 1'b0;
        repeat (8) @(posedge CLK_PAD_IO);
        #1;

        $display("[TB] CMD0, no response");
        pushExp(K_VALID, 6'd0, 32'h0, '0, 0, 0);
        applyStimulus(48'h40_00000000_95);
        waitDrain();

        $display("[TB] CMD8, short response, request held off until NCR");
        RESP_TYPE = 2'b10;
        RESP_REQ  = 1'b1;
        RESP_DATA = 128'h1AA;
        pushExp(K_VALID, 6'd8, 32'h000001AA, '0, 0, 0);
        pushExp(K_RESP, '0, '0, 136'(48'h08_000001AA_13), 48, 2);
        applyStimulus(48'h48_000001AA_87);
        waitDrain();
        RESP_REQ  = 1'b0;
        RESP_TYPE = 2'b00;

        $display("[TB] CMD0 with corrupted CRC");
`ifdef SD_CMD_CRC_CHECK_EN
        RESP_TYPE = 2'b10;
        RESP_REQ  = 1'b1;
        pushExp(K_CRC, '0, '0, '0, 0, 0);
`else
        pushExp(K_VALID, 6'd0, 32'h0, '0, 0, 0);
`endif
        applyStimulus(48'h40_00000000_97);
        waitDrain();
        RESP_REQ  = 1'b0;
        RESP_TYPE = 2'b00;

        $display("[TB] transmission bit 0");
        pushExp(K_FRAME, '0, '0, '0, 0, 0);
        applyStimulus(48'h00_00000000_95);
        waitDrain();

        $display("[TB] end bit 0");
        pushExp(K_FRAME, '0, '0, '0, 0, 0);
        applyStimulus(48'h40_00000000_94);
        waitDrain();

        $display("[TB] CMD8 with no response request, line activity while waiting");
        RESP_TYPE = 2'b10;
        pushExp(K_VALID, 6'd8, 32'h000001AA, '0, 0, 0);
        pushExp(K_TO, '0, '0, '0, 0, 64);
        applyStimulus(48'h48_000001AA_87);
        repeat (5) sendBit(1'b0);
        cmd_dat_i = 1'b1;
        waitDrain();
        RESP_TYPE = 2'b00;
        pushExp(K_VALID, 6'd0, 32'h0, '0, 0, 0);
        applyStimulus(48'h40_00000000_95);
        waitDrain();

        $display("[TB] CMD8 with long response");
        RESP_TYPE = 2'b01;
        RESP_REQ  = 1'b1;
        RESP_DATA = {120'h48_000001AA, 8'hC3};
        pushExp(K_VALID, 6'd8, 32'h000001AA, '0, 0, 0);
        pushExp(K_RESP, '0, '0, {2'b00, 6'h3F, 120'h48_000001AA, 7'h43, 1'b1}, 136, 2);
        applyStimulus(48'h48_000001AA_87);
        waitDrain();

        $display("[TB] reset during long response");
        RESP_DATA = 128'h1;
        pushExp(K_VALID, 6'd8, 32'h000001AA, '0, 0, 0);
        applyStimulus(48'h48_000001AA_87);
        sent = 0;
        n = 0;
        while (sent < 70 && n < 2000) begin
            @(negedge CLK_PAD_IO);
            if (BIT_EN && cmd_oe_o) sent = sent + 1;
            n = n + 1;
        end
        checkOutput("bits driven before reset", 136'(sent), 136'(70));
        #2;
        RST_PAD_I = 1'b1;
        #1;
        checkOutput("mid-send reset cmd_oe_o", 136'(cmd_oe_o), 136'(0));
        checkOutput("mid-send reset cmd_out_o", 136'(cmd_out_o), 136'(1));
        checkOutput("mid-send reset BUSY", 136'(BUSY), 136'(0));
        checkOutput("mid-send reset CMD_INDEX", 136'(CMD_INDEX), 136'(0));
        checkOutput("mid-send reset ARG", 136'(ARG), 136'(0));
        RESP_REQ  = 1'b0;
        RESP_TYPE = 2'b00;
        repeat (4) @(posedge CLK_PAD_IO);
        #1;
        RST_PAD_I = 1'b0;
        repeat (20) @(posedge CLK_PAD_IO);
        #1;
        checkOutput("after reset BUSY", 136'(BUSY), 136'(0));
        checkOutput("after reset cmd_oe_o", 136'(cmd_oe_o), 136'(0));
        pushExp(K_VALID, 6'd0, 32'h0, '0, 0, 0);
        applyStimulus(48'h40_00000000_95);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
